cache_controller: RTL

Direct-mapped, read-only cache controller sitting between the processor's load path and `main_memory`. It is the initiator on the memory block-fetch interface.
- It looks up each request in a 1024-set, 4-word-block cache.
- On a miss it drives the address with `hit` low for one cycle, captures the four returned words, fills the line and answers the processor.
- It keeps saturating hit and miss counters for the hit-rate measurements this design exists to produce.

---
 rtl/cache_pkg.sv | 39 +++
 rtl/cache_array.sv | 56 +++++
 rtl/cache_controller.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared constants, FSM state encoding and address-field helpers
//               for the direct-mapped read-only cache controller.
//               Word address layout: tag [14:12], index [11:2], offset [1:0].
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int SETS        = 1024;
    localparam int TAG_W       = 3;
    localparam int WORD_LENGTH = 32;
    localparam int OFFSET_W    = 2;
    localparam int INDEX_W     = 10;
    localparam int ADDR_W      = TAG_W + INDEX_W + OFFSET_W;
    localparam int WORDS       = 1 << OFFSET_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        FETCH   = 2'd2,
        FILL    = 2'd3
    } state_t;

    function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] a);
        return a[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] addr_index(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [OFFSET_W-1:0] addr_offset(input logic [ADDR_W-1:0] a);
        return a[OFFSET_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_array.sv
`default_nettype none
// ============================================================================
// Module      : cache_array
// Description : Tag, valid and 4-word data storage for the direct-mapped cache.
//               Combinational read by index, synchronous whole-line write.
//               Valid bits clear asynchronously on rst_n; tag/data are not reset.
// Ports       : clk, rst_n       - clock, async active-low reset
//               index            - line selected for read and write
//               rd_valid/rd_tag  - valid bit and tag of the selected line
//               rd_line          - the four data words of the selected line
//               wr_en            - write wr_tag/wr_line into the line, set valid
// Revision    : 1.0 - initial release
// ============================================================================
module cache_array #(
    parameter int SETS        = 1024,
    parameter int TAG_W       = 3,
    parameter int WORD_LENGTH = 32
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [$clog2(SETS)-1:0]                      index,
    output logic                                         rd_valid,
    output logic [TAG_W-1:0]                             rd_tag,
    output logic [cache_pkg::WORDS-1:0][WORD_LENGTH-1:0] rd_line,
    input  logic                                         wr_en,
    input  logic [TAG_W-1:0]                             wr_tag,
    input  logic [cache_pkg::WORDS-1:0][WORD_LENGTH-1:0] wr_line
);
    import cache_pkg::*;

    logic [SETS-1:0]                      r_valid;
    logic [TAG_W-1:0]                     r_tag  [SETS];
    logic [WORDS-1:0][WORD_LENGTH-1:0]    r_data [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else if (wr_en) begin
            r_valid[index] <= 1'b1;
        end
    end

    // Payload storage carries no reset so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_tag[index]  <= wr_tag;
            r_data[index] <= wr_line;
        end
    end

    assign rd_valid = r_valid[index];
    assign rd_tag   = r_tag[index];
    assign rd_line  = r_data[index];

endmodule
`default_nettype wire

// File: rtl/cache_controller.sv
`default_nettype none
// ============================================================================
// Module      : cache_controller
// Description : Direct-mapped read-only cache between the CPU load path and
//               main_memory. Hits answer one cycle after acceptance; misses
//               issue a one-cycle block fetch (mem_hit=0) and answer with the
//               forwarded memory word three cycles after acceptance.
//               Saturating hit/miss counters.
// Ports       : cpu_req/cpu_addr/cpu_ready     - request side
//               cpu_resp_valid/cpu_rdata       - response side
//               mem_address/mem_hit            - block fetch request
//               mem_data1..4                   - block words, offsets 0..3
//               hit_count/miss_count           - saturating statistics
// Revision    : 1.0 - initial release
// ============================================================================
module cache_controller #(
    parameter int SETS        = 1024,
    parameter int TAG_W       = 3,
    parameter int WORD_LENGTH = 32,
    parameter int CNT_W       = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpu_req,
    input  logic [TAG_W+$clog2(SETS)+1:0]   cpu_addr,
    output logic                            cpu_ready,
    output logic                            cpu_resp_valid,
    output logic [WORD_LENGTH-1:0]          cpu_rdata,
    output logic [TAG_W+$clog2(SETS)+1:0]   mem_address,
    output logic                            mem_hit,
    input  logic [WORD_LENGTH-1:0]          mem_data1,
    input  logic [WORD_LENGTH-1:0]          mem_data2,
    input  logic [WORD_LENGTH-1:0]          mem_data3,
    input  logic [WORD_LENGTH-1:0]          mem_data4,
    output logic [CNT_W-1:0]                hit_count,
    output logic [CNT_W-1:0]                miss_count
);
    import cache_pkg::*;

    localparam int c_addr_w = TAG_W + $clog2(SETS) + OFFSET_W;

    state_t                             r_state;
    state_t                             w_state_next;
    logic [c_addr_w-1:0]                r_addr_q;
    logic [CNT_W-1:0]                   r_hit_count;
    logic [CNT_W-1:0]                   r_miss_count;
    logic [WORD_LENGTH-1:0]             r_rdata_last;

    logic                               w_valid;
    logic [TAG_W-1:0]                   w_tag;
    logic [WORDS-1:0][WORD_LENGTH-1:0]  w_line;
    logic [WORDS-1:0][WORD_LENGTH-1:0]  w_mem_line;
    logic                               w_lookup_hit;
    logic                               w_hit_inc;
    logic                               w_miss_inc;
    logic [WORD_LENGTH-1:0]             w_resp_word;

    assign w_mem_line = {mem_data4, mem_data3, mem_data2, mem_data1};

    cache_array #(
        .SETS        (SETS),
        .TAG_W       (TAG_W),
        .WORD_LENGTH (WORD_LENGTH)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .index    (addr_index(r_addr_q)),
        .rd_valid (w_valid),
        .rd_tag   (w_tag),
        .rd_line  (w_line),
        .wr_en    (r_state == FILL),
        .wr_tag   (addr_tag(r_addr_q)),
        .wr_line  (w_mem_line)
    );

    assign w_lookup_hit = w_valid && (w_tag == addr_tag(r_addr_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_addr_q <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == IDLE && cpu_req) begin
                r_addr_q <= cpu_addr;
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        cpu_ready      = 1'b0;
        cpu_resp_valid = 1'b0;
        w_resp_word    = r_rdata_last;
        mem_hit        = 1'b1;
        mem_address    = '0;
        w_hit_inc      = 1'b0;
        w_miss_inc     = 1'b0;
        case (r_state)
            IDLE: begin
                cpu_ready = 1'b1;
                if (cpu_req) begin
                    w_state_next = COMPARE;
                end
            end
            COMPARE: begin
                if (w_lookup_hit) begin
                    cpu_resp_valid = 1'b1;
                    w_resp_word    = w_line[addr_offset(r_addr_q)];
                    w_hit_inc      = 1'b1;
                    w_state_next   = IDLE;
                end else begin
                    w_miss_inc     = 1'b1;
                    w_state_next   = FETCH;
                end
            end
            FETCH: begin
                mem_hit      = 1'b0;
                mem_address  = {r_addr_q[c_addr_w-1:OFFSET_W], {OFFSET_W{1'b0}}};
                w_state_next = FILL;
            end
            FILL: begin
                // Memory word is forwarded straight through while the line is written.
                cpu_resp_valid = 1'b1;
                w_resp_word    = w_mem_line[addr_offset(r_addr_q)];
                w_state_next   = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // cpu_rdata keeps the last response between pulses.
    assign cpu_rdata = w_resp_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_last <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (cpu_resp_valid) begin
                r_rdata_last <= w_resp_word;
            end
            if (w_hit_inc && (r_hit_count != '1)) begin
                r_hit_count <= r_hit_count + CNT_W'(1);
            end
            if (w_miss_inc && (r_miss_count != '1)) begin
                r_miss_count <= r_miss_count + CNT_W'(1);
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;

endmodule
`default_nettype wire
